// File: rtl/seg_scanner.sv
// Time-multiplexed N-digit 7-segment scanner: dwell-based digit rotation, anti-ghosting
// blank interval, per-digit enable/blink and selectable output polarity.
module seg_scanner #(
  parameter int DIGITS       = 8,
  parameter int CLK_HZ       = 10000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 256,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4*DIGITS-1:0]         content,
  input  logic [DIGITS-1:0]           dp,
  input  logic [DIGITS-1:0]           en,
  input  logic [DIGITS-1:0]           blink,
  output logic [DIGITS-1:0]           an,
  output logic [6:0]                  seg,
  output logic                        seg_dp,
  output logic [$clog2(DIGITS)-1:0]   digit_idx,
  output logic                        frame_tick
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW    = $clog2(DWELL);
  localparam int IW    = $clog2(DIGITS);
  localparam int FW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0]     PRE_LAST  = PW'(DWELL - 1);
  localparam logic [PW-1:0]     PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRM_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic              POL       = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{POL}};
  localparam logic [6:0]        SEG_OFF   = {7{POL}};

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     prescaler_q, prescaler_d;
  logic [IW-1:0]     digit_idx_q, digit_idx_d;
  logic              frame_tick_q, frame_tick_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [6:0]        sh_pat_q, sh_pat_d;
  logic              sh_dp_q, sh_dp_d;
  logic              sh_en_q, sh_en_d;
  logic              sh_blink_q, sh_blink_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;

  logic [DIGITS-1:0] onehot;
  logic              wrap;
  logic              dark;

  function automatic logic [6:0] decode7(input logic [3:0] n);
    case (n)
      4'h0: decode7 = 7'h3F;
      4'h1: decode7 = 7'h06;
      4'h2: decode7 = 7'h5B;
      4'h3: decode7 = 7'h4F;
      4'h4: decode7 = 7'h66;
      4'h5: decode7 = 7'h6D;
      4'h6: decode7 = 7'h7D;
      4'h7: decode7 = 7'h07;
      4'h8: decode7 = 7'h7F;
      4'h9: decode7 = 7'h6F;
      4'hA: decode7 = 7'h77;
      4'hB: decode7 = 7'h7C;
      4'hC: decode7 = 7'h39;
      4'hD: decode7 = 7'h5E;
      4'hE: decode7 = 7'h79;
      default: decode7 = 7'h71;
    endcase
  endfunction

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
    assign onehot[gi] = (digit_idx_q == IW'(gi));
  end

  always_comb begin
    wrap         = (prescaler_q == PRE_LAST);
    prescaler_d  = wrap ? '0 : prescaler_q + PW'(1);
    digit_idx_d  = digit_idx_q;
    frame_tick_d = 1'b0;
    if (wrap) begin
      digit_idx_d  = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IW'(1);
      frame_tick_d = (digit_idx_q == IDX_LAST);
    end

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick_q) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // State tracks the prescaler value it is registered alongside.
    state_d = (prescaler_d < PRE_BLANK) ? ST_BLANK : ST_DRIVE;

    // Shadow copy is taken once per dwell so mid-dwell input changes cannot tear.
    sh_pat_d   = sh_pat_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    sh_blink_d = sh_blink_q;
    if (prescaler_q == '0) begin
      sh_pat_d   = decode7(content[{digit_idx_q, 2'b00} +: 4]);
      sh_dp_d    = dp[digit_idx_q];
      sh_en_d    = en[digit_idx_q];
      sh_blink_d = blink[digit_idx_q];
    end

    dark     = ~sh_en_q | (sh_blink_q & blink_phase_q);
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    seg_dp_d = POL;
    if (state_q == ST_DRIVE && !dark) begin
      an_d     = onehot ^ AN_OFF;
      seg_d    = sh_pat_q ^ SEG_OFF;
      seg_dp_d = sh_dp_q ^ POL;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_BLANK;
      prescaler_q   <= '0;
      digit_idx_q   <= '0;
      frame_tick_q  <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_pat_q      <= '0;
      sh_dp_q       <= 1'b0;
      sh_en_q       <= 1'b0;
      sh_blink_q    <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= POL;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      digit_idx_q   <= digit_idx_d;
      frame_tick_q  <= frame_tick_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_pat_q      <= sh_pat_d;
      sh_dp_q       <= sh_dp_d;
      sh_en_q       <= sh_en_d;
      sh_blink_q    <= sh_blink_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner: 4 digits, 10-cycle dwell, 2-cycle blank, 2-frame blink.
module tb_seg_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] content;
  logic [3:0]  dp, en, blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Inputs the expected values are derived from (may lag the DUT inputs on purpose).
  logic [15:0] m_content;
  logic [3:0]  m_en, m_dp, m_blink;

  seg_scanner #(
    .DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2),
    .BLINK_FRAMES(2), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .content(content), .dp(dp), .en(en),
    .blink(blink), .an(an), .seg(seg), .seg_dp(seg_dp),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'h3F; 4'h1: pat = 7'h06; 4'h2: pat = 7'h5B; 4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66; 4'h5: pat = 7'h6D; 4'h6: pat = 7'h7D; 4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F; 4'h9: pat = 7'h6F; 4'hA: pat = 7'h77; 4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39; 4'hD: pat = 7'h5E; 4'hE: pat = 7'h79; default: pat = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic check_idle();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(seg_dp), 32'h1);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
  endtask

  // Outputs at sample t reflect the scan position one edge earlier (u = t-1).
  task automatic check_model();
    int u, pre, d;
    logic drv;
    logic [3:0] an_e, nib;
    logic [6:0] seg_e;
    logic dp_e;
    u   = t - 1;
    pre = u % 10;
    d   = (u / 10) % 4;
    drv = (pre >= 2) && m_en[d] && !(m_blink[d] && (((u / 80) % 2) == 1));
    nib = m_content[d*4 +: 4];
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (drv) begin
      an_e  = ~(4'b0001 << d);
      seg_e = ~pat(nib);
      dp_e  = ~m_dp[d];
    end
    chk("an", 32'(an), 32'(an_e));
    chk("seg", 32'(seg), 32'(seg_e));
    chk("seg_dp", 32'(seg_dp), 32'(dp_e));
    chk("digit_idx", 32'(digit_idx), 32'((t / 10) % 4));
    chk("frame_tick", 32'(frame_tick), 32'((t % 40) == 0));
  endtask

  task automatic run_to(input int t_end);
    while (t < t_end) begin
      @(posedge clock);
      t++;
      @(negedge clock);
      check_model();
    end
  endtask

  initial begin
    reset   = 1'b0;
    content = 16'hF8A0; en = 4'hF; dp = 4'h0; blink = 4'h0;
    m_content = content; m_en = en; m_dp = dp; m_blink = blink;

    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_idle();
    end
    $display("step reset: idle outputs held for 5 cycles");
    reset = 1'b1;

    run_to(120);
    $display("step scan: 3 frames of F8A0 checked");

    // Tearing: DUT content changes mid-dwell of digit 0; expectation keeps the old value.
    run_to(125);
    content[3:0] = 4'h1;
    run_to(130);
    chk("tear_seg", 32'(seg), 32'h40);
    run_to(160);
    $display("step tearing: digit 0 held ~3F through its dwell");

    m_content = content;
    en = 4'b1011; dp = 4'b0001;
    m_en = en; m_dp = dp;
    run_to(170);
    chk("new_seg", 32'(seg), 32'h79);
    run_to(240);
    $display("step enable/dp: digit 2 dark, digit 0 dp shown");

    en = 4'hF; dp = 4'h0; blink = 4'b0010;
    m_en = en; m_dp = dp; m_blink = blink;
    run_to(255);
    chk("blink_dark", 32'(an), 32'hF);
    run_to(335);
    chk("blink_on", 32'(an), 32'hD);
    run_to(400);
    $display("step blink: digit 1 dark 2 frames then driven 2 frames");

    run_to(425);
    chk("pre_rst_an", 32'(an), 32'hB);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_idle();
    end
    reset = 1'b1;
    t = 0;
    run_to(40);
    $display("step mid-drive reset: outputs idle, scan restarted from digit 0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
